// File: rtl/chesssoc_pio_pkg.sv
// Shared register map, bus payload and helpers for the chess SoC parallel I/O ports.
package chesssoc_pio_pkg;

  localparam int unsigned PIO_DATA_W = 32;
  localparam int unsigned PIO_ADDR_W = 2;
  localparam int unsigned PIO_MAX_W  = 16;

  localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_DATA    = PIO_ADDR_W'(0);
  localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_IRQMASK = PIO_ADDR_W'(2);
  localparam logic [PIO_ADDR_W-1:0] PIO_ADDR_EDGECAP = PIO_ADDR_W'(3);

  // One Avalon-MM slave access as seen in a single cycle.
  typedef struct packed {
    logic [PIO_ADDR_W-1:0] addr;
    logic                  rd;
    logic                  wr;
    logic [PIO_DATA_W-1:0] wdata;
  } pio_req_t;

  // Zero-extend a port-sized register image onto the read bus.
  function automatic logic [PIO_DATA_W-1:0] pio_zext(input logic [PIO_MAX_W-1:0] v);
    return PIO_DATA_W'(v);
  endfunction

endpackage

// File: rtl/chesssoc_button_debounce.sv
// Single-bit debouncer: the output follows the input only after it has held
// a new level for DEBOUNCE_CYCLES consecutive clocks.
module chesssoc_button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic idle_level,
  input  logic din,
  output logic dout
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;
  logic             w_differ;
  logic             w_done;

  assign w_differ = din ^ r_stable;
  assign w_done   = w_differ && (r_cnt == CNT_LAST);

  // Any return to the stable level restarts the hold window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_stable <= idle_level;
    end else if (!w_differ) begin
      r_cnt    <= '0;
    end else if (w_done) begin
      r_cnt    <= '0;
      r_stable <= din;
    end else begin
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  assign dout = r_stable;

endmodule

// File: rtl/chesssoc_button_pio.sv
// Avalon-MM push-button input port with sync, edge capture and level IRQ.
// Per-bit debouncers are built only when BUTTON_PIO_DEBOUNCE_EN is defined.
module chesssoc_button_pio
  import chesssoc_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CAPTURE_FALLING = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PIO_ADDR_W-1:0] address,
  input  logic                  chipselect,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic [PIO_DATA_W-1:0] writedata,
  output logic [PIO_DATA_W-1:0] readdata,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  localparam logic [WIDTH-1:0] IDLE_LEVEL = (CAPTURE_FALLING != 0) ? '1 : '0;

  if (WIDTH < 1 || WIDTH > PIO_MAX_W || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("chesssoc_button_pio: parameter out of range");
  end

  pio_req_t              w_req;
  logic [WIDTH-1:0]      r_sync1;
  logic [WIDTH-1:0]      r_sync2;
  logic [WIDTH-1:0]      w_stable;
  logic [WIDTH-1:0]      r_prev;
  logic [WIDTH-1:0]      w_edge;
  logic [WIDTH-1:0]      w_w1c;
  logic [WIDTH-1:0]      r_irqmask;
  logic [WIDTH-1:0]      r_edgecap;
  logic [PIO_DATA_W-1:0] w_rdata;
  logic [PIO_DATA_W-1:0] r_readdata;
  logic                  r_irq;
  logic                  w_unused;

  assign w_req.addr  = address;
  assign w_req.rd    = chipselect & ~read_n;
  assign w_req.wr    = chipselect & ~write_n;
  assign w_req.wdata = writedata;
  assign w_unused    = ^w_req.wdata[PIO_DATA_W-1:WIDTH];

  // Two-flop synchronizer; resets to the idle level so no edge follows reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= IDLE_LEVEL;
      r_sync2 <= IDLE_LEVEL;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

`ifdef BUTTON_PIO_DEBOUNCE_EN
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_db
    chesssoc_button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk       (clk),
      .reset     (reset),
      .idle_level(IDLE_LEVEL[gi]),
      .din       (r_sync2[gi]),
      .dout      (w_stable[gi])
    );
  end
`else
  logic [WIDTH-1:0] r_stable;

  always_ff @(posedge clk) begin
    if (reset) r_stable <= IDLE_LEVEL;
    else       r_stable <= r_sync2;
  end

  assign w_stable = r_stable;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_prev <= IDLE_LEVEL;
    else       r_prev <= w_stable;
  end

  if (CAPTURE_FALLING != 0) begin : g_fall
    assign w_edge = r_prev & ~w_stable;
  end else begin : g_rise
    assign w_edge = ~r_prev & w_stable;
  end

  assign w_w1c = (w_req.wr && (w_req.addr == PIO_ADDR_EDGECAP)) ? w_req.wdata[WIDTH-1:0] : '0;

  // A new edge outranks a same-cycle W1C so no press is ever lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irqmask <= '0;
      r_edgecap <= '0;
    end else begin
      if (w_req.wr && (w_req.addr == PIO_ADDR_IRQMASK)) begin
        r_irqmask <= w_req.wdata[WIDTH-1:0];
      end
      r_edgecap <= (r_edgecap & ~w_w1c) | w_edge;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_req.addr)
      PIO_ADDR_DATA:    w_rdata = pio_zext(PIO_MAX_W'(w_stable));
      PIO_ADDR_IRQMASK: w_rdata = pio_zext(PIO_MAX_W'(r_irqmask));
      PIO_ADDR_EDGECAP: w_rdata = pio_zext(PIO_MAX_W'(r_edgecap));
      default:          w_rdata = '0;
    endcase
  end

  // Read data is held between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_req.rd) r_readdata <= w_rdata;
      r_irq <= |(r_edgecap & r_irqmask);
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule
